// File: rtl/prf_freelist.sv
// Circular free list of physical register tags with speculative and commit heads.
// Optional sticky illegal-operation flag `err` is built when FREELIST_ERR_EN is defined.
module prf_freelist #(
  parameter int ISSUE_WIDTH = 2,
  parameter int PRF_DEPTH   = 64,
  parameter int ARF_DEPTH   = 32,
  parameter int PRF_WIDTH   = $clog2(PRF_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ISSUE_WIDTH-1:0]                alloc_req,
  output logic                                  alloc_gnt,
  output logic [ISSUE_WIDTH-1:0][PRF_WIDTH-1:0] alloc_tag,
  input  logic [ISSUE_WIDTH-1:0]                free_en,
  input  logic [ISSUE_WIDTH-1:0][PRF_WIDTH-1:0] free_tag,
  input  logic [ISSUE_WIDTH-1:0]                commit_en,
  input  logic                                  flush,
  output logic [PRF_WIDTH:0]                    free_cnt,
  output logic                                  empty
`ifdef FREELIST_ERR_EN
  ,
  output logic                                  err
`endif
);

  localparam int PW = PRF_WIDTH + 1;
  localparam logic [PW-1:0] CAP = PW'(PRF_DEPTH - ARF_DEPTH);

  logic [PRF_WIDTH-1:0] fl_q [PRF_DEPTH];
  logic [PW-1:0] head_q, chead_q, tail_q;
  logic [PW-1:0] n_alloc, n_commit, n_free, chead_nxt, head_nxt;
  logic [ISSUE_WIDTH-1:0] wr_en;
  logic [ISSUE_WIDTH-1:0][PRF_WIDTH-1:0] wr_idx;
`ifdef FREELIST_ERR_EN
  logic free_err, commit_err;
`endif

  function automatic logic [PW-1:0] popcnt(input logic [ISSUE_WIDTH-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  assign free_cnt = tail_q - head_q;
  assign empty    = (free_cnt == '0);

  always_comb begin
    logic [PW-1:0] ofs;
    logic [PW-1:0] rank;
    logic [PW-1:0] addr;
`ifdef FREELIST_ERR_EN
    logic [PW-1:0] dist;
    logic          dup;
`endif
    n_alloc   = popcnt(alloc_req);
    n_commit  = popcnt(commit_en);
    alloc_gnt = rst_n && !flush && (n_alloc <= free_cnt);
    chead_nxt = chead_q + n_commit;
`ifdef FREELIST_ERR_EN
    free_err   = 1'b0;
    commit_err = 1'b0;
    if (n_commit > (head_q - chead_q)) begin
      chead_nxt  = head_q;
      commit_err = 1'b1;
    end
`endif
    if (flush)          head_nxt = chead_nxt;
    else if (alloc_gnt) head_nxt = head_q + n_alloc;
    else                head_nxt = head_q;

    // Requested slots take consecutive entries from head, skipping idle slots.
    ofs = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      addr         = head_q + ofs;
      alloc_tag[i] = fl_q[addr[PRF_WIDTH-1:0]];
      ofs          = ofs + PW'(alloc_req[i]);
    end

    rank = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      wr_en[i] = free_en[i] && (free_tag[i] != '0);
`ifdef FREELIST_ERR_EN
      if (wr_en[i]) begin
        dup = 1'b0;
        for (int k = 0; k < PRF_DEPTH; k++) begin
          dist           = PW'(k) - {1'b0, head_q[PRF_WIDTH-1:0]};
          dist[PW-1]     = 1'b0;
          if (dist < free_cnt && fl_q[k] == free_tag[i]) dup = 1'b1;
        end
        for (int j = 0; j < i; j++)
          if (wr_en[j] && free_tag[j] == free_tag[i]) dup = 1'b1;
        // Occupancy is judged against the post-edge head so a same-cycle grant makes room.
        if (dup || ((tail_q + rank - head_nxt) >= CAP)) begin
          wr_en[i] = 1'b0;
          free_err = 1'b1;
        end
      end
`endif
      addr      = tail_q + rank;
      wr_idx[i] = addr[PRF_WIDTH-1:0];
      rank      = rank + PW'(wr_en[i]);
    end
    n_free = rank;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= CAP;
      for (int k = 0; k < PRF_DEPTH; k++)
        fl_q[k] <= (k < PRF_DEPTH - ARF_DEPTH) ? PRF_WIDTH'(ARF_DEPTH + k) : '0;
`ifdef FREELIST_ERR_EN
      err <= 1'b0;
`endif
    end else begin
      head_q  <= head_nxt;
      chead_q <= chead_nxt;
      tail_q  <= tail_q + n_free;
      for (int i = 0; i < ISSUE_WIDTH; i++)
        if (wr_en[i]) fl_q[wr_idx[i]] <= free_tag[i];
`ifdef FREELIST_ERR_EN
      err <= err | free_err | commit_err;
`endif
    end
  end

endmodule

// File: tb/tb_prf_freelist.sv
// Scoreboard bench for prf_freelist: driver pushes expected outputs, a negedge monitor pops and compares.
module tb_prf_freelist;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       alloc_req;
  logic             alloc_gnt;
  logic [1:0][5:0]  alloc_tag;
  logic [1:0]       free_en;
  logic [1:0][5:0]  free_tag;
  logic [1:0]       commit_en;
  logic             flush;
  logic [6:0]       free_cnt;
  logic             empty;
`ifdef FREELIST_ERR_EN
  logic             err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string nm;
    int    g;
    int    t0;
    int    t1;
    int    c;
    int    e;
  } exp_t;

  exp_t sb[$];

  prf_freelist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc_req (alloc_req),
    .alloc_gnt (alloc_gnt),
    .alloc_tag (alloc_tag),
    .free_en   (free_en),
    .free_tag  (free_tag),
    .commit_en (commit_en),
    .flush     (flush),
    .free_cnt  (free_cnt),
    .empty     (empty)
`ifdef FREELIST_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      if (x.g >= 0)  chk({x.nm, ".gnt"}, int'(alloc_gnt), x.g);
      if (x.t0 >= 0) chk({x.nm, ".tag0"}, int'(alloc_tag[0]), x.t0);
      if (x.t1 >= 0) chk({x.nm, ".tag1"}, int'(alloc_tag[1]), x.t1);
      if (x.c >= 0) begin
        chk({x.nm, ".cnt"}, int'(free_cnt), x.c);
        chk({x.nm, ".empty"}, int'(empty), (x.c == 0) ? 1 : 0);
      end
`ifdef FREELIST_ERR_EN
      if (x.e >= 0)  chk({x.nm, ".err"}, int'(err), x.e);
`endif
    end
  end

  task automatic step(input logic [1:0] req, input logic [1:0] fe,
                      input logic [5:0] f0, input logic [5:0] f1,
                      input logic [1:0] ce, input logic fl, input string nm,
                      input int g, input int t0, input int t1, input int c, input int e);
    exp_t x;
    alloc_req   = req;
    free_en     = fe;
    free_tag[0] = f0;
    free_tag[1] = f1;
    commit_en   = ce;
    flush       = fl;
    x.nm = nm; x.g = g; x.t0 = t0; x.t1 = t1; x.c = c; x.e = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, "rst", 0, -1, -1, -1, -1);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ref_q[$];
    int infl[$];
    int x, y, slot, fs;
    logic [1:0] fe, req;
    logic [5:0] f0, f1;

    rst_n = 1'b0; alloc_req = '0; free_en = '0; free_tag = '0; commit_en = '0; flush = 1'b0;
    @(posedge clk);
    #1;

    // Dual allocation from reset
    do_reset();
    step(2'b11, 2'b00, 0, 0, 2'b00, 0, "t1_alloc", 1, 32, 33, 32, 0);
    step(2'b00, 2'b00, 0, 0, 2'b00, 0, "t1_cnt", 1, -1, -1, 30, -1);

    // Only slot 1 requests: packed onto the head entry
    do_reset();
    step(2'b10, 2'b00, 0, 0, 2'b00, 0, "t2_slot1", 1, -1, 32, 32, -1);
    step(2'b01, 2'b00, 0, 0, 2'b00, 0, "t2_slot0", 1, 33, -1, 31, -1);
    step(2'b00, 2'b00, 0, 0, 2'b00, 0, "t2_cnt", 1, -1, -1, 30, -1);

    // Drain to one entry; a same-cycle free is not visible until the next cycle
    do_reset();
    for (int k = 0; k < 15; k++)
      step(2'b11, 2'b00, 0, 0, 2'b00, 0, "t3_drain", 1, 32 + 2*k, 33 + 2*k, 32 - 2*k, -1);
    step(2'b01, 2'b00, 0, 0, 2'b00, 0, "t3_last", 1, 62, -1, 2, -1);
    step(2'b11, 2'b01, 6'd40, 0, 2'b11, 0, "t3_block", 0, -1, -1, 1, -1);
    step(2'b11, 2'b00, 0, 0, 2'b00, 0, "t3_vis", 1, 63, 40, 2, -1);
    step(2'b01, 2'b00, 0, 0, 2'b00, 0, "t3_empty", 0, -1, -1, 0, -1);

    // Speculative allocation, commit, flush with same-cycle commit, zero-tag frees
    do_reset();
    step(2'b11, 2'b00, 0, 0, 2'b00, 0, "t4_a0", 1, 32, 33, 32, -1);
    step(2'b11, 2'b00, 0, 0, 2'b00, 0, "t4_a1", 1, 34, 35, 30, -1);
    step(2'b11, 2'b00, 0, 0, 2'b00, 0, "t4_a2", 1, 36, 37, 28, -1);
    step(2'b00, 2'b00, 0, 0, 2'b11, 0, "t4_commit", 1, -1, -1, 26, -1);
    step(2'b11, 2'b00, 0, 0, 2'b01, 1, "t4_flush", 0, -1, -1, 26, -1);
    step(2'b01, 2'b00, 0, 0, 2'b00, 0, "t4_after", 1, 35, -1, 29, -1);
    step(2'b00, 2'b01, 6'd0, 0, 2'b00, 0, "t4_zero", 1, -1, -1, 28, -1);
    step(2'b00, 2'b11, 6'd0, 6'd33, 2'b00, 0, "t4_zero2", 1, -1, -1, 28, -1);
    step(2'b00, 2'b00, 0, 0, 2'b00, 0, "t4_cnt", 1, -1, -1, 29, -1);

    // Steady alloc/free pairs wrapping the pointers several times
    do_reset();
    for (int k = 32; k < 64; k++) ref_q.push_back(k);
    for (int k = 1; k < 32; k++) infl.push_back(k);
    for (int i = 0; i < 200; i++) begin
      slot = i % 2;
      fs   = (i % 3 == 0) ? 1 : 0;
      x = ref_q.pop_front();
      y = infl.pop_front();
      ref_q.push_back(y);
      infl.push_back(x);
      req = (slot == 1) ? 2'b10 : 2'b01;
      fe  = (fs == 1) ? 2'b10 : 2'b01;
      if (i % 5 == 0) fe = 2'b11;
      f0 = (fs == 0) ? 6'(y) : 6'd0;
      f1 = (fs == 1) ? 6'(y) : 6'd0;
      step(req, fe, f0, f1, 2'b00, 0, "t5_pair", 1,
           (slot == 0) ? x : -1, (slot == 1) ? x : -1, 32, -1);
    end
    step(2'b00, 2'b00, 0, 0, 2'b00, 0, "t5_end", 1, -1, -1, 32, -1);

`ifdef FREELIST_ERR_EN
    // Overfilling free is dropped and raises a sticky flag cleared only by reset
    do_reset();
    step(2'b00, 2'b00, 0, 0, 2'b00, 0, "t6_clean", 1, -1, -1, 32, 0);
    step(2'b00, 2'b01, 6'd5, 0, 2'b00, 0, "t6_over", 1, -1, -1, 32, 0);
    step(2'b00, 2'b00, 0, 0, 2'b00, 0, "t6_err", 1, -1, -1, 32, 1);
    step(2'b00, 2'b00, 0, 0, 2'b00, 0, "t6_sticky", 1, -1, -1, 32, 1);
    rst_n = 1'b0;
    step(2'b00, 2'b00, 0, 0, 2'b00, 0, "t6_inrst", 0, -1, -1, 32, 1);
    rst_n = 1'b1;
    step(2'b00, 2'b00, 0, 0, 2'b00, 0, "t6_cleared", 1, -1, -1, 32, 0);
`endif

    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prf_freelist.md
Name: prf_freelist

Overview:
- Circular free list of physical register tags for the rename stage, directly upstream of the physical register file.
- Supplies up to ISSUE_WIDTH destination tags per cycle; these become the PRF write addresses.
- Reclaims tags of overwritten mappings at retire.
- Keeps a speculative head and a commit head so a pipeline flush restores every speculatively allocated tag in one cycle.

Parameters:
- ISSUE_WIDTH, 2, allocate/free/commit ports per cycle.
- PRF_DEPTH, 64, physical registers; power of two.
- ARF_DEPTH, 32, architectural registers; p0..p(ARF_DEPTH-1) are mapped at reset.
- PRF_WIDTH, log2(PRF_DEPTH), tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- alloc_req  in  ISSUE_WIDTH  per-slot tag request; any bit pattern is legal.
- alloc_gnt  out  1  all requested slots granted this cycle.
- alloc_tag  out  ISSUE_WIDTH x PRF_WIDTH  tag for slot i; valid only when alloc_req[i] && alloc_gnt.
- free_en  in  ISSUE_WIDTH  retire returns an old tag.
- free_tag  in  ISSUE_WIDTH x PRF_WIDTH  tag being returned.
- commit_en  in  ISSUE_WIDTH  retiring instruction that allocated a tag; makes that allocation non-speculative.
- flush  in  1  mispredict/exception recovery.
- free_cnt  out  PRF_WIDTH+1  entries available for allocation.
- empty  out  1  free_cnt == 0.

Behaviour:
- Storage: PRF_DEPTH x PRF_WIDTH array.
- Pointers: head (speculative), chead (commit) and tail, each PRF_WIDTH+1 bits; the MSB is the wrap bit.
- free_cnt = tail - head, computed from registered values.
- Reset: entry k = ARF_DEPTH+k for k < PRF_DEPTH-ARF_DEPTH, remaining entries 0; head = chead = 0; tail = PRF_DEPTH-ARF_DEPTH; free_cnt = 32 with defaults; alloc_gnt = 0 while rst_n is low.
- Allocation is combinational from the current head.
  - n = popcount(alloc_req).
  - alloc_gnt = (n <= free_cnt) && !flush; n = 0 gives alloc_gnt = 1.
  - alloc_tag[i] = array[head + popcount(alloc_req[i-1:0])]; requested slots are packed, with no holes consumed.
  - On grant, head += n at the clock edge. No partial grants.
- Free: each free_en[i] with free_tag[i] != 0 writes array[tail + rank_i]; tail += number of valid frees.
  - Rank is among valid frees only, slot order.
  - free_tag == 0 (zero register) is silently dropped.
- Commit: chead += popcount(commit_en).
- Flush: head := chead + popcount(commit_en) from the same cycle. Allocation is suppressed that cycle; frees in the same cycle still apply.
- Same-cycle alloc and free: tags freed in cycle t are not visible to allocation until t+1. Grant is decided from pre-edge free_cnt.
- Wrap-around: pointers wrap modulo PRF_DEPTH via the low bits; the wrap bit disambiguates full and empty.
- Capacity: free_cnt never legally exceeds PRF_DEPTH-ARF_DEPTH.
- Reset mid-operation: all pointers and the array return to reset values on the next edge with rst_n low; in-flight requests are discarded.

Optional Feature:
- Macro: FREELIST_ERR_EN.
- When defined, adds output err (1 bit, sticky until reset). err sets when any of these occurs:
  - a free would raise free_cnt above PRF_DEPTH-ARF_DEPTH; the offending frees are dropped;
  - a commit would move chead past head; chead is clamped to head;
  - a valid free returns a tag already present between head and tail; that free is dropped.
- When undefined: no err port and no checks. Illegal frees and commits are written unchecked, and behaviour is undefined.

Test Plan:
- Reset, then alloc_req=2'b11 -> alloc_gnt=1, alloc_tag={32,33}; next cycle free_cnt=30.
- alloc_req=2'b10 from reset -> alloc_tag[1]=32; alloc_tag[0] is don't-care; head advances by 1.
- Drain to free_cnt=1, then alloc_req=2'b11 with free_en=2'b01, free_tag[0]=40 in the same cycle -> alloc_gnt=0; next cycle free_cnt=2 and alloc_req=2'b11 is granted, with tag 40 as the second tag.
- Allocate 6 tags, commit 2, then flush with commit_en=2'b01 -> alloc_gnt=0 that cycle; next cycle head=chead=3, free_cnt=29, next alloc_tag[0]=35.
- Cycle 200 alloc/free pairs across wrap-around while checking against a reference queue -> every tag is unique, free_cnt stays at 32, and free_tag=0 never changes free_cnt.
- With FREELIST_ERR_EN, free a 33rd tag from reset -> err=1, free_cnt stays 32; err remains 1 until rst_n is low for one edge.
